// File: rtl/shift_seq_if.sv
// Command channel between a producer and the shift sequencer.
interface shift_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq.sv
// Command sequencer driving a chain of WIDTH 1-bit shifter cells (select, parallel
// data and end-of-chain serial bits). One command per handshake, done pulse at end.
module shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_if.slave       cmd,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_r,
  output logic             ser_l,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpShr  = 2'b01;
  localparam logic [1:0] OpShl  = 2'b10;
  localparam logic [1:0] OpRor  = 2'b11;

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelLoad  = 2'b01;
  localparam logic [1:0] SelRight = 2'b10;
  localparam logic [1:0] SelLeft  = 2'b11;

  localparam logic [CNT_W-1:0] WidthC = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] OneC   = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             done_q, done_d;
  logic             accept;
  logic [CNT_W-1:0] amt_sat;

  assign cmd.cmd_ready = rst_n & (state_q == StIdle);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  // Shifting more than WIDTH places is never useful; ROR by WIDTH is identity.
  assign amt_sat       = (cmd.cmd_amt > WidthC) ? WidthC : cmd.cmd_amt;

  // Next-state, counter, latched command fields and registered chain controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    par_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = cmd.cmd_op;
          fill_d = cmd.cmd_fill;
          if (cmd.cmd_op == OpLoad) begin
            state_d = StLoad;
            cnt_d   = '0;
            par_d   = cmd.cmd_data;
          end else begin
            cnt_d   = amt_sat;
            state_d = (amt_sat == '0) ? StDone : StShift;
          end
        end
      end
      StLoad:  state_d = StDone;
      StShift: begin
        cnt_d = cnt_q - OneC;
        if (cnt_q <= OneC) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Select follows the state being entered so it is valid for that whole cycle.
    s_d = SelHold;
    if (state_d == StLoad) begin
      s_d = SelLoad;
    end else if (state_d == StShift) begin
      s_d = (op_d == OpShl) ? SelLeft : SelRight;
    end
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpLoad;
      fill_q  <= 1'b0;
      s_q     <= SelHold;
      par_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      s_q     <= s_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  assign s       = s_q;
  assign par_out = par_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);
  // Rotate feeds the LSB back into the MSB cell; plain shifts inject the fill bit.
  assign ser_r   = (op_q == OpRor) ? q_in[0] : ((op_q == OpShr) ? fill_q : 1'b0);
  assign ser_l   = (op_q == OpShl) ? fill_q : 1'b0;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: drives a behavioural shifter chain and checks final chain
// values, done/ready timing and select activity against a reference model.
module tb_shift_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] chain = '0;
  logic [1:0]   s;
  logic [W-1:0] par_out;
  logic         ser_r, ser_l, busy, done;

  int errors = 0;
  int checks = 0;

  shift_seq_if #(.WIDTH(W), .CNT_W(4)) cmd_if ();

  shift_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd_if.slave),
    .q_in    (chain),
    .s       (s),
    .par_out (par_out),
    .ser_r   (ser_r),
    .ser_l   (ser_l),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Shifter chain: each cell is a DFF behind a 4:1 mux.
  always @(posedge clk) begin
    case (s)
      2'b01:   chain <= par_out;
      2'b10:   chain <= {ser_r, chain[W-1:1]};
      2'b11:   chain <= {chain[W-2:0], ser_l};
      default: chain <= chain;
    endcase
  end

  function automatic void check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Reference: final chain value from the command semantics.
  function automatic logic [W-1:0] model(input logic [1:0] op, input int amt,
                                         input logic [W-1:0] data, input logic fill,
                                         input logic [W-1:0] v);
    int k;
    logic [2*W-1:0] wide, ones;
    k = (amt > W) ? W : amt;
    wide = {{W{1'b0}}, v};
    ones = (k == 0) ? '0 : ((2*W)'(1) << k) - 1;
    case (op)
      2'b00:   return data;
      2'b01:   return W'(wide >> k) | (fill ? W'(ones << (W - k)) : '0);
      2'b10:   return W'(wide << k) | (fill ? W'(ones) : '0);
      default: return W'((wide >> k) | (wide << (W - k)));
    endcase
  endfunction

  function automatic int exp_done(input logic [1:0] op, input int amt);
    if (op == 2'b00) return 2;
    return ((amt > W) ? W : amt) + 1;
  endfunction

  // Issue one command and observe it to completion (cycle n = n-th cycle after accept).
  task automatic run_cmd(input logic [1:0] op, input int amt, input logic [W-1:0] data,
                         input logic fill, input bit pulse_busy,
                         output int done_at, output int act, output int bad,
                         output int ready_at);
    int guard;
    logic [1:0] code;
    code = (op == 2'b00) ? 2'b01 : ((op == 2'b10) ? 2'b11 : 2'b10);
    done_at = -1; act = 0; bad = 0; ready_at = -1;
    guard = 0;
    while (!cmd_if.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_if.cmd_ready) check("ready_wait", 0, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_amt   = 4'(amt);
    cmd_if.cmd_data  = data;
    cmd_if.cmd_fill  = fill;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (s == code) act++;
      else if (s != 2'b00) bad++;
      if (s == 2'b01 && par_out != data) bad++;
      if (s != 2'b01 && par_out != '0) bad++;
      if (done) begin
        if (done_at < 0) done_at = n;
        else bad++;
      end
      if (done_at >= 0 && n > done_at && cmd_if.cmd_ready) begin
        ready_at = n;
        cmd_if.cmd_valid = 1'b0;
        break;
      end
      // Optional stray command during busy must be ignored.
      if (pulse_busy && done_at < 0 && (n % 2) == 1) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 8'h3C;
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
    end
    if (ready_at < 0) check("cmd_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0] op;
    int         amt;
    logic [7:0] data;
    logic       fill;
    bit         pulse;
    logic [7:0] exp_chain;
    int         exp_done;
    int         exp_act;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int d, a, b, r, amt;
    logic [1:0] op;
    logic [7:0] data, exp_v;
    logic fill;

    vecs[0] = '{2'b00, 0,  8'hA5, 1'b0, 1'b0, 8'hA5, 2, 1};
    vecs[1] = '{2'b01, 3,  8'h00, 1'b0, 1'b1, 8'h14, 4, 3};
    vecs[2] = '{2'b00, 0,  8'h81, 1'b0, 1'b0, 8'h81, 2, 1};
    vecs[3] = '{2'b10, 2,  8'h00, 1'b1, 1'b0, 8'h07, 3, 2};
    vecs[4] = '{2'b00, 0,  8'hA5, 1'b0, 1'b0, 8'hA5, 2, 1};
    vecs[5] = '{2'b11, 4,  8'h00, 1'b0, 1'b0, 8'h5A, 5, 4};
    vecs[6] = '{2'b00, 0,  8'hA5, 1'b0, 1'b0, 8'hA5, 2, 1};
    vecs[7] = '{2'b11, 15, 8'h00, 1'b0, 1'b0, 8'hA5, 9, 8};
    vecs[8] = '{2'b01, 0,  8'h00, 1'b1, 1'b0, 8'hA5, 1, 0};

    // Reset held two edges with a command offered.
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_amt   = 4'd0;
    cmd_if.cmd_data  = 8'hFF;
    cmd_if.cmd_fill  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s", int'(s), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_if.cmd_ready), 0);
    check("rst_par", int'(par_out), 0);
    cmd_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", int'(cmd_if.cmd_ready), 1);
    check("rel_busy", int'(busy), 0);
    check("rel_chain", int'(chain), 0);

    // Directed table.
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].fill, vecs[i].pulse,
              d, a, b, r);
      check($sformatf("vec%0d_chain", i), int'(chain), int'(vecs[i].exp_chain));
      check($sformatf("vec%0d_done_at", i), d, vecs[i].exp_done);
      check($sformatf("vec%0d_active", i), a, vecs[i].exp_act);
      check($sformatf("vec%0d_bad", i), b, 0);
      check($sformatf("vec%0d_ready_at", i), r, vecs[i].exp_done + 1);
    end

    // Reset in the 3rd cycle of SHR by 6: three shifts land, then everything clears.
    run_cmd(2'b00, 0, 8'hFF, 1'b0, 1'b0, d, a, b, r);
    check("mid_preload", int'(chain), 8'hFF);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b01;
    cmd_if.cmd_amt   = 4'd6;
    cmd_if.cmd_fill  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("mid_s_c1", int'(s), 2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_s", int'(s), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_ready_lo", int'(cmd_if.cmd_ready), 0);
    check("mid_chain", int'(chain), 8'h1F);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ready", int'(cmd_if.cmd_ready), 1);
    check("mid_done2", int'(done), 0);
    check("mid_chain2", int'(chain), 8'h1F);

    // Random commands against the reference model.
    exp_v = chain;
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      amt  = $urandom_range(0, 15);
      data = 8'($urandom);
      fill = 1'($urandom);
      exp_v = model(op, amt, data, fill, exp_v);
      run_cmd(op, amt, data, fill, 1'($urandom), d, a, b, r);
      check($sformatf("rnd%0d_chain", i), int'(chain), int'(exp_v));
      check($sformatf("rnd%0d_done_at", i), d, exp_done(op, amt));
      check($sformatf("rnd%0d_active", i), a, exp_done(op, amt) - 1);
      check($sformatf("rnd%0d_bad", i), b, 0);
      check($sformatf("rnd%0d_ready_at", i), r, exp_done(op, amt) + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
